// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - two-requester round-robin arbiter sharing one 32-bit carry-select adder
// Optional macro ADD_ARB_OVF_EN adds registered signed-overflow outputs resp_ovf_0/resp_ovf_1.
module add_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic             req_cin_0,
  output logic             resp_valid_0,
  input  logic             resp_ready_0,
  output logic [WIDTH-1:0] resp_sum_0,
  output logic             resp_cout_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic             req_cin_1,
  output logic             resp_valid_1,
  input  logic             resp_ready_1,
  output logic [WIDTH-1:0] resp_sum_1,
`ifdef ADD_ARB_OVF_EN
  output logic             resp_ovf_0,
  output logic             resp_ovf_1,
`endif
  output logic             resp_cout_1
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_ptr;
  logic             r_gnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_any;
  logic             w_gnt;
  logic             w_accept;
  logic             w_resp_done;
  logic             w_resp_live;

  logic [15:0]      w_lo_sum;
  logic             w_lo_cout;
  logic [16:0]      w_hi_c0;
  logic [16:0]      w_hi_c1;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  // Lower half ripples bit by bit; upper half is precomputed for both carry-ins.
  always_comb begin
    logic v_c;
    v_c      = r_cin;
    w_lo_sum = '0;
    for (int i = 0; i < 16; i++) begin
      w_lo_sum[i] = r_a[i] ^ r_b[i] ^ v_c;
      v_c         = (r_a[i] & r_b[i]) | (v_c & (r_a[i] ^ r_b[i]));
    end
    w_lo_cout = v_c;
  end

  assign w_hi_c0 = {1'b0, r_a[31:16]} + {1'b0, r_b[31:16]};
  assign w_hi_c1 = {1'b0, r_a[31:16]} + {1'b0, r_b[31:16]} + 17'd1;
  assign w_sum   = {(w_lo_cout ? w_hi_c1[15:0] : w_hi_c0[15:0]), w_lo_sum};
  assign w_cout  = w_lo_cout ? w_hi_c1[16] : w_hi_c0[16];
  assign w_ovf   = (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);

  // Pointer only matters when both requesters contend.
  assign w_any       = req_valid_0 | req_valid_1;
  assign w_gnt       = (req_valid_0 & req_valid_1) ? r_ptr : req_valid_1;
  assign w_accept    = reset_n & (r_state == S_IDLE) & w_any;
  assign w_resp_live = reset_n & (r_state == S_RESP);
  assign w_resp_done = w_resp_live & (r_gnt ? resp_ready_1 : resp_ready_0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_gnt   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_gnt <= w_gnt;
        r_a   <= w_gnt ? req_a_1   : req_a_0;
        r_b   <= w_gnt ? req_b_1   : req_b_0;
        r_cin <= w_gnt ? req_cin_1 : req_cin_0;
      end
      if (r_state == S_EXEC) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
      end
      if (w_resp_done) begin
        r_ptr <= ~r_gnt;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    req_ready_0  = 1'b0;
    req_ready_1  = 1'b0;
    resp_valid_0 = 1'b0;
    resp_valid_1 = 1'b0;
    resp_sum_0   = '0;
    resp_sum_1   = '0;
    resp_cout_0  = 1'b0;
    resp_cout_1  = 1'b0;
`ifdef ADD_ARB_OVF_EN
    resp_ovf_0   = 1'b0;
    resp_ovf_1   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_EXEC;
        req_ready_0 = w_accept & ~w_gnt;
        req_ready_1 = w_accept & w_gnt;
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        if (w_resp_done) w_next = S_IDLE;
        resp_valid_0 = w_resp_live & ~r_gnt;
        resp_valid_1 = w_resp_live & r_gnt;
        resp_sum_0   = resp_valid_0 ? r_sum : '0;
        resp_sum_1   = resp_valid_1 ? r_sum : '0;
        resp_cout_0  = resp_valid_0 & r_cout;
        resp_cout_1  = resp_valid_1 & r_cout;
`ifdef ADD_ARB_OVF_EN
        resp_ovf_0   = resp_valid_0 & r_ovf;
        resp_ovf_1   = resp_valid_1 & r_ovf;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - directed self-checking bench for add_arbiter
module tb_add_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic        req_cin_0, req_cin_1;
  logic        resp_valid_0, resp_valid_1;
  logic        resp_ready_0, resp_ready_1;
  logic [31:0] resp_sum_0, resp_sum_1;
  logic        resp_cout_0, resp_cout_1;
`ifdef ADD_ARB_OVF_EN
  logic        resp_ovf_0, resp_ovf_1;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  add_arbiter #(.WIDTH(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid_0  (req_valid_0),
    .req_ready_0  (req_ready_0),
    .req_a_0      (req_a_0),
    .req_b_0      (req_b_0),
    .req_cin_0    (req_cin_0),
    .resp_valid_0 (resp_valid_0),
    .resp_ready_0 (resp_ready_0),
    .resp_sum_0   (resp_sum_0),
    .resp_cout_0  (resp_cout_0),
    .req_valid_1  (req_valid_1),
    .req_ready_1  (req_ready_1),
    .req_a_1      (req_a_1),
    .req_b_1      (req_b_1),
    .req_cin_1    (req_cin_1),
    .resp_valid_1 (resp_valid_1),
    .resp_ready_1 (resp_ready_1),
    .resp_sum_1   (resp_sum_1),
`ifdef ADD_ARB_OVF_EN
    .resp_ovf_0   (resp_ovf_0),
    .resp_ovf_1   (resp_ovf_1),
`endif
    .resp_cout_1  (resp_cout_1)
  );

  // Drives one isolated transaction and reports what was observed at each phase.
  task automatic run_txn(input logic x, input logic [31:0] a, input logic [31:0] b, input logic cin,
                         output logic rdy, output logic vld, output logic [31:0] sum,
                         output logic cout, output logic ovf, output logic vld_after);
    @(negedge clock);
    if (x) begin
      req_valid_1 = 1'b1; req_a_1 = a; req_b_1 = b; req_cin_1 = cin;
    end else begin
      req_valid_0 = 1'b1; req_a_0 = a; req_b_0 = b; req_cin_0 = cin;
    end
    #1 rdy = x ? req_ready_1 : req_ready_0;
    @(negedge clock);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    @(negedge clock);
    #1;
    vld  = x ? resp_valid_1 : resp_valid_0;
    sum  = x ? resp_sum_1   : resp_sum_0;
    cout = x ? resp_cout_1  : resp_cout_0;
`ifdef ADD_ARB_OVF_EN
    ovf  = x ? resp_ovf_1   : resp_ovf_0;
`else
    ovf  = 1'b0;
`endif
    if (x) resp_ready_1 = 1'b1; else resp_ready_0 = 1'b1;
    @(negedge clock);
    resp_ready_0 = 1'b0;
    resp_ready_1 = 1'b0;
    #1 vld_after = x ? resp_valid_1 : resp_valid_0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    @(negedge clock);
    #1;
    n_total++; if (req_ready_0 !== 1'b0) $display("FAIL reset_req_ready_0: got %b want 0", req_ready_0); else n_pass++;
    n_total++; if (req_ready_1 !== 1'b0) $display("FAIL reset_req_ready_1: got %b want 0", req_ready_1); else n_pass++;
    n_total++; if ({resp_valid_0, resp_valid_1} !== 2'b00) $display("FAIL reset_resp_valid: got %b want 00", {resp_valid_0, resp_valid_1}); else n_pass++;
    n_total++; if ({resp_sum_0, resp_sum_1} !== 64'h0) $display("FAIL reset_resp_sum: got %h want 0", {resp_sum_0, resp_sum_1}); else n_pass++;
    n_total++; if ({resp_cout_0, resp_cout_1} !== 2'b00) $display("FAIL reset_resp_cout: got %b want 00", {resp_cout_0, resp_cout_1}); else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    #1;
    n_total++; if ({req_ready_0, req_ready_1} !== 2'b00) $display("FAIL idle_no_req_ready: got %b want 00", {req_ready_0, req_ready_1}); else n_pass++;
    n_total++; if ({resp_valid_0, resp_valid_1} !== 2'b00) $display("FAIL post_reset_resp_valid: got %b want 00", {resp_valid_0, resp_valid_1}); else n_pass++;
  endtask

  task automatic test_single();
    logic rdy, vld, cout, ovf, vld_after;
    logic [31:0] sum;
    run_txn(1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0, rdy, vld, sum, cout, ovf, vld_after);
    n_total++; if (rdy !== 1'b1) $display("FAIL single_req_ready: got %b want 1", rdy); else n_pass++;
    n_total++; if (vld !== 1'b1) $display("FAIL single_resp_valid: got %b want 1", vld); else n_pass++;
    n_total++; if (sum !== 32'h0000_0008) $display("FAIL single_sum: got %h want 00000008", sum); else n_pass++;
    n_total++; if (cout !== 1'b0) $display("FAIL single_cout: got %b want 0", cout); else n_pass++;
    n_total++; if (vld_after !== 1'b0) $display("FAIL single_resp_drop: got %b want 0", vld_after); else n_pass++;
  endtask

  task automatic test_wrap();
    logic rdy, vld, cout, ovf, vld_after;
    logic [31:0] sum;
    run_txn(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, rdy, vld, sum, cout, ovf, vld_after);
    n_total++; if (rdy !== 1'b1) $display("FAIL wrap_req_ready: got %b want 1", rdy); else n_pass++;
    n_total++; if (sum !== 32'h0000_0000) $display("FAIL wrap_sum: got %h want 00000000", sum); else n_pass++;
    n_total++; if (cout !== 1'b1) $display("FAIL wrap_cout: got %b want 1", cout); else n_pass++;
`ifdef ADD_ARB_OVF_EN
    n_total++; if (ovf !== 1'b0) $display("FAIL wrap_ovf: got %b want 0", ovf); else n_pass++;
`endif
  endtask

  task automatic test_carry();
    logic rdy, vld, cout, ovf, vld_after;
    logic [31:0] sum;
    run_txn(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, rdy, vld, sum, cout, ovf, vld_after);
    n_total++; if (rdy !== 1'b1) $display("FAIL carry_req_ready_1: got %b want 1", rdy); else n_pass++;
    n_total++; if (vld !== 1'b1) $display("FAIL carry_resp_valid_1: got %b want 1", vld); else n_pass++;
    n_total++; if (sum !== 32'h0001_0000) $display("FAIL carry_sum: got %h want 00010000", sum); else n_pass++;
    n_total++; if (cout !== 1'b0) $display("FAIL carry_cout: got %b want 0", cout); else n_pass++;
    run_txn(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, rdy, vld, sum, cout, ovf, vld_after);
    n_total++; if (sum !== 32'hFFFF_FFFE) $display("FAIL ovf_sum: got %h want FFFFFFFE", sum); else n_pass++;
    n_total++; if (cout !== 1'b0) $display("FAIL ovf_cout: got %b want 0", cout); else n_pass++;
`ifdef ADD_ARB_OVF_EN
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ovf); else n_pass++;
`endif
    run_txn(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, rdy, vld, sum, cout, ovf, vld_after);
    n_total++; if (sum !== 32'hACF1_3569) $display("FAIL mixed_sum: got %h want ACF13569", sum); else n_pass++;
    n_total++; if (cout !== 1'b0) $display("FAIL mixed_cout: got %b want 0", cout); else n_pass++;
`ifdef ADD_ARB_OVF_EN
    n_total++; if (ovf !== 1'b0) $display("FAIL mixed_ovf: got %b want 0", ovf); else n_pass++;
`endif
  endtask

  task automatic test_contention();
    logic [31:0] exp_sum;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    req_valid_0 = 1'b1; req_a_0 = 32'h1;  req_b_0 = 32'h1;  req_cin_0 = 1'b0;
    req_valid_1 = 1'b1; req_a_1 = 32'h10; req_b_1 = 32'h20; req_cin_1 = 1'b0;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      n_total++; if ({req_ready_1, req_ready_0} !== ((g % 2) ? 2'b10 : 2'b01))
        $display("FAIL contention_grant%0d: got %b want %b", g, {req_ready_1, req_ready_0}, ((g % 2) ? 2'b10 : 2'b01)); else n_pass++;
      @(negedge clock);
      #1;
      n_total++; if ({req_ready_1, req_ready_0} !== 2'b00) $display("FAIL contention_exec_ready%0d: got %b want 00", g, {req_ready_1, req_ready_0}); else n_pass++;
      @(negedge clock);
      #1;
      exp_sum = (g % 2) ? 32'h30 : 32'h2;
      n_total++; if ({resp_valid_1, resp_valid_0} !== ((g % 2) ? 2'b10 : 2'b01))
        $display("FAIL contention_resp_valid%0d: got %b want %b", g, {resp_valid_1, resp_valid_0}, ((g % 2) ? 2'b10 : 2'b01)); else n_pass++;
      n_total++; if (((g % 2) ? resp_sum_1 : resp_sum_0) !== exp_sum)
        $display("FAIL contention_sum%0d: got %h want %h", g, ((g % 2) ? resp_sum_1 : resp_sum_0), exp_sum); else n_pass++;
      n_total++; if (((g % 2) ? resp_sum_0 : resp_sum_1) !== 32'h0)
        $display("FAIL contention_other_sum%0d: got %h want 0", g, ((g % 2) ? resp_sum_0 : resp_sum_1)); else n_pass++;
      @(negedge clock);
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    resp_ready_0 = 1'b0; resp_ready_1 = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    req_valid_1 = 1'b1; req_a_1 = 32'h100; req_b_1 = 32'h23; req_cin_1 = 1'b0;
    resp_ready_0 = 1'b1;
    #1;
    n_total++; if ({req_ready_1, req_ready_0} !== 2'b10) $display("FAIL bp_grant1: got %b want 10", {req_ready_1, req_ready_0}); else n_pass++;
    @(negedge clock);
    req_valid_0 = 1'b1; req_a_0 = 32'h2; req_b_0 = 32'h3; req_cin_0 = 1'b0;
    @(negedge clock);
    for (int c = 0; c < 5; c++) begin
      req_a_1 = 32'hDEAD_0000 + c;
      #1;
      n_total++; if (resp_valid_1 !== 1'b1) $display("FAIL bp_hold_valid%0d: got %b want 1", c, resp_valid_1); else n_pass++;
      n_total++; if (resp_sum_1 !== 32'h123) $display("FAIL bp_hold_sum%0d: got %h want 00000123", c, resp_sum_1); else n_pass++;
      n_total++; if ({req_ready_0, resp_valid_0} !== 2'b00) $display("FAIL bp_hold_other%0d: got %b want 00", c, {req_ready_0, resp_valid_0}); else n_pass++;
      @(negedge clock);
    end
    resp_ready_0 = 1'b0;
    resp_ready_1 = 1'b1;
    #1;
    n_total++; if (resp_valid_1 !== 1'b1) $display("FAIL bp_release_valid: got %b want 1", resp_valid_1); else n_pass++;
    @(negedge clock);
    resp_ready_1 = 1'b0;
    #1;
    n_total++; if (resp_valid_1 !== 1'b0) $display("FAIL bp_drop_valid: got %b want 0", resp_valid_1); else n_pass++;
    n_total++; if ({req_ready_1, req_ready_0} !== 2'b01) $display("FAIL bp_regrant0: got %b want 01", {req_ready_1, req_ready_0}); else n_pass++;
    req_valid_1 = 1'b0;
    @(negedge clock);
    req_valid_0 = 1'b0;
    @(negedge clock);
    #1;
    n_total++; if (resp_sum_0 !== 32'h5) $display("FAIL bp_sum0: got %h want 00000005", resp_sum_0); else n_pass++;
    resp_ready_0 = 1'b1;
    @(negedge clock);
    resp_ready_0 = 1'b0;
  endtask

  task automatic test_reset_exec();
    req_valid_1 = 1'b1; req_a_1 = 32'h1; req_b_1 = 32'h1; req_cin_1 = 1'b0;
    #1;
    n_total++; if ({req_ready_1, req_ready_0} !== 2'b10) $display("FAIL rst_exec_grant1: got %b want 10", {req_ready_1, req_ready_0}); else n_pass++;
    @(negedge clock);
    req_valid_1 = 1'b0;
    reset_n = 1'b0;
    resp_ready_1 = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    n_total++; if ({req_ready_0, req_ready_1, resp_valid_0, resp_valid_1} !== 4'b0000)
      $display("FAIL rst_exec_flags: got %b want 0000", {req_ready_0, req_ready_1, resp_valid_0, resp_valid_1}); else n_pass++;
    n_total++; if ({resp_sum_0, resp_sum_1, resp_cout_0, resp_cout_1} !== 66'h0)
      $display("FAIL rst_exec_data: got %h want 0", {resp_sum_0, resp_sum_1, resp_cout_0, resp_cout_1}); else n_pass++;
    @(negedge clock);
    #1;
    n_total++; if (resp_valid_1 !== 1'b0) $display("FAIL rst_exec_no_resp: got %b want 0", resp_valid_1); else n_pass++;
    resp_ready_1 = 1'b0;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    #1;
    n_total++; if ({req_ready_1, req_ready_0} !== 2'b01) $display("FAIL rst_exec_ptr0: got %b want 01", {req_ready_1, req_ready_0}); else n_pass++;
    @(negedge clock);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    @(negedge clock);
    resp_ready_0 = 1'b1;
    @(negedge clock);
    resp_ready_0 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_a_0 = '0; req_b_0 = '0; req_cin_0 = 1'b0;
    req_a_1 = '0; req_b_1 = '0; req_cin_1 = 1'b0;
    resp_ready_0 = 1'b0; resp_ready_1 = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_carry();
    test_contention();
    test_backpressure();
    test_reset_exec();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width; only 32 is supported.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req_valid_x  input  1  requester x (x in {0,1}) presents an add request.
REQ-005 SHALL have ports req_ready_x  output  1  request from x accepted this cycle.
REQ-006 SHALL have ports req_a_x, req_b_x  input  WIDTH  operands from requester x.
REQ-007 SHALL have ports req_cin_x  input  1  carry-in from requester x.
REQ-008 SHALL have ports resp_valid_x  output  1  result for x is available.
REQ-009 SHALL have ports resp_ready_x  input  1  requester x consumes the result.
REQ-010 SHALL have ports resp_sum_x  output  WIDTH  and resp_cout_x  output  1  sum and carry-out for x.

Function
REQ-011 SHALL share exactly one internal 32-bit carry-select adder (16-bit lower ripple, duplicated upper 16-bit halves, carry-selected) between both requesters.
REQ-012 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; reset state IDLE.
REQ-013 IDLE: if any req_valid_x high, SHALL grant one requester, assert its req_ready_x combinationally in that cycle, latch its A, B, Cin and grant id, and go to EXEC.
REQ-014 IDLE with no req_valid SHALL stay in IDLE with both req_ready low.
REQ-015 Both valid in IDLE SHALL grant the requester indicated by the round-robin pointer; single valid SHALL be granted regardless of pointer.
REQ-016 EXEC: SHALL drive the adder from the latched operands and register Sum[31:0] and Cout into the result register; go to RESP after one cycle.
REQ-017 RESP: SHALL assert resp_valid only for the granted requester; resp_sum/resp_cout SHALL be stable while resp_valid is high.
REQ-018 RESP with granted resp_ready high SHALL deassert resp_valid next cycle, set pointer to the non-granted requester, and go to IDLE.
REQ-019 RESP with resp_ready low SHALL hold indefinitely; resp_ready of the non-granted requester SHALL be ignored.
REQ-020 req_ready_x SHALL be low in EXEC and RESP; req_valid/operand changes there SHALL have no effect.
REQ-021 Latency: request accepted at edge N yields resp_valid high from cycle N+2; minimum spacing between accepts is 3 cycles.
REQ-022 Sum SHALL be (A+B+Cin) mod 2^32, Cout bit 32 of the 33-bit result; wrap-around (e.g. FFFFFFFF+1) SHALL give Sum 0, Cout 1.
REQ-023 resp_sum_x/resp_cout_x of the non-granted requester SHALL read 0.

Reset
REQ-024 reset_n low at a rising edge SHALL force IDLE, pointer to requester 0, result register and latched operands to 0.
REQ-025 During and after reset all req_ready_x, resp_valid_x, resp_sum_x, resp_cout_x SHALL be 0.
REQ-026 Reset mid-transaction (EXEC or RESP) SHALL discard the transaction with no response delivered.

Configuration
REQ-027 Macro ADD_ARB_OVF_EN defined SHALL add ports resp_ovf_x  output  1  signed overflow (A[31]==B[31] and Sum[31]!=A[31]), registered with the sum, 0 on reset and for the non-granted requester.
REQ-028 Macro ADD_ARB_OVF_EN undefined SHALL omit resp_ovf_x ports and logic; all other behaviour identical.

Verification
REQ-029 Single request: x=0, A=00000005, B=00000003, Cin=0 -> req_ready_0 same cycle, resp_valid_0 two cycles later, Sum=00000008, Cout=0.
REQ-030 Wrap: A=FFFFFFFF, B=00000000, Cin=1 -> Sum=00000000, Cout=1; with ADD_ARB_OVF_EN ovf=0.
REQ-031 Carry across halves: A=0000FFFF, B=00000001, Cin=0 -> Sum=00010000, Cout=0; with ADD_ARB_OVF_EN, A=B=7FFFFFFF -> Sum=FFFFFFFE, ovf=1.
REQ-032 Contention: both valid continuously after reset -> grants alternate 0,1,0,1; each response only on its own resp_valid.
REQ-033 Backpressure: resp_ready_1 low 5 cycles in RESP -> resp_valid_1 and resp_sum_1 held stable, req_ready_0 low throughout, grant to 0 on IDLE return.
REQ-034 Reset in EXEC: reset_n low one cycle -> all outputs 0 next cycle, no resp_valid, next grant goes to requester 0.
